// File: rtl/fake_tdc_gen.sv
// -----------------------------------------------------------------------------
// fake_tdc_gen
//
// Synthetic TDC event source used for bring-up without the real TDC front end.
// One data word is generated every programmable period. Successive words cycle
// through the emulated channels in round-robin order. Each word is offered to
// the FIFO writer with wr_en. Events that arrive while the previous word is
// still unacknowledged are dropped and reported.
//
// Handshake: wr_en is a level "valid". Once it rises it stays high, and data
// and channel stay stable, until f_FIFO_writing_done is sampled high on a
// rising edge. done acts as a one-cycle "ready/accept" for the current word.
// done sampled while wr_en is low has no effect. If a new tick coincides with
// done, the old word is accepted and the new word is loaded in the same cycle,
// so wr_en stays high.
//
// Optional build macro:
//   FAKE_TDC_JITTER_EN - adds 0..15 pseudo-random extra cycles to every period,
//                        driven by a 16-bit Fibonacci LFSR (taps 16,14,13,11).
//
// Parameters:
//   CHANNELS   - number of emulated channels (1..256)
//   DATA_WIDTH - output word width; must exceed CH_W
//   CNT_WIDTH  - width of the period counter and of the period input
//
// Ports:
//   clk                 in   clock, all logic on rising edge
//   rst                 in   synchronous active-high reset
//   enable              in   run/stop event generation
//   period              in   event period in clocks (0 behaves as 1)
//   f_FIFO_writing_done in   one-cycle acknowledge of the current word
//   wr_en               out  word valid, held until acknowledged
//   data                out  {channel index, sequence count}
//   channel             out  channel index of the current word
//   overrun             out  sticky: an event was dropped
//   drop_cnt            out  number of dropped events, saturating
// -----------------------------------------------------------------------------
module fake_tdc_gen #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 30,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  period,
  input  logic                  f_FIFO_writing_done,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] data,
  output logic [CH_W-1:0]       channel,
  output logic                  overrun,
  output logic [15:0]           drop_cnt
);

  localparam int SEQ_W = DATA_WIDTH - CH_W;
  // One spare bit lets the jittered threshold exceed the period range
  // without wrapping.
  localparam int CW = CNT_WIDTH + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       thresh;
  logic [CNT_WIDTH-1:0] peff_m1;
  logic [CH_W-1:0]     ptr;
  logic [SEQ_W-1:0]    seq;
  logic                tick;
  logic                done;

  assign done = f_FIFO_writing_done;

`ifdef FAKE_TDC_JITTER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // The LFSR steps once per tick, including ticks whose event is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (tick) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end
`endif

  // A zero period behaves as a period of one.
  always_comb begin
    peff_m1 = '0;
    if (period != '0) begin
      peff_m1 = period - 1'b1;
    end
  end

`ifdef FAKE_TDC_JITTER_EN
  assign thresh = {1'b0, peff_m1} + CW'(lfsr[3:0]);
`else
  assign thresh = {1'b0, peff_m1};
`endif

  // ">=" rather than "==": if period shrinks below the running count,
  // the next tick fires at once instead of waiting for a counter wrap.
  // The counter also runs in IDLE. Because of that, the first word
  // appears exactly Peff edges after enable is first sampled high.
  assign tick = enable && (cnt >= thresh);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      seq      <= '0;
      wr_en    <= 1'b0;
      data     <= '0;
      channel  <= '0;
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      // Period counter: cleared when stopped or on a tick, else runs.
      if (!enable || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A word is loaded on every tick unless a pending word blocks it.
      if (tick && (state != HOLD || done)) begin
        wr_en   <= 1'b1;
        data    <= {ptr, seq};
        channel <= ptr;
        ptr     <= (ptr == LAST_CH) ? '0 : ptr + 1'b1;
        seq     <= seq + 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state <= tick ? HOLD : COUNT;
          end
        end
        COUNT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (tick) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (tick && !done) begin
            // Writer still busy: drop the event, keep the pending word.
            overrun <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
              drop_cnt <= drop_cnt + 1'b1;
            end
          end else if (!tick && done) begin
            wr_en <= 1'b0;
            state <= enable ? COUNT : IDLE;
          end
        end
        default: begin
          state <= IDLE;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fake_tdc_gen.md
# fake_tdc_gen

Parametrised synthetic TDC event source for bring-up without the real TDC front end. It emits one data word per programmable period across a configurable number of channels in round-robin order. Each word is presented with `wr_en`, which stays high until the FIFO writer acknowledges it with `f_FIFO_writing_done`. The block sits in front of the FIFO writer in place of the TDC, and it detects and reports events dropped because the writer was still busy.

## Interface
- `CHANNELS`, default 4: number of emulated channels, 1..256.
- `DATA_WIDTH`, default 24: output word width (3-byte word), must exceed `CH_W`.
- `CNT_WIDTH`, default 30: width of the period counter and of the `period` input.
- `CH_W` (localparam): max(1, clog2(`CHANNELS`)).

Ports (name, direction, width, meaning):
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: run/stop of event generation.
- `period` input `CNT_WIDTH`: event period in clocks; 0 is treated as 1.
- `f_FIFO_writing_done` input 1: one-cycle acknowledge of the current word.
- `wr_en` output 1: word valid; held high until acknowledged.
- `data` output `DATA_WIDTH`: {channel index [`CH_W`], sequence count [`DATA_WIDTH`-`CH_W`]}.
- `channel` output `CH_W`: channel index of the current word.
- `overrun` output 1: sticky; an event was dropped because the previous word was still pending.
- `drop_cnt` output 16: count of dropped events; saturates at 16'hFFFF.

## Operation
- Reset value of every output and register is 0: `wr_en`, `data`, `channel`, `overrun`, `drop_cnt`, period counter, sequence counter, channel pointer.

State machine: IDLE, COUNT, HOLD.
- **IDLE:** `enable`=0 and no word pending; counter held at 0. Goes to COUNT when `enable`=1.
- **COUNT:** counter increments each cycle.
  - A tick occurs when counter >= Peff-1, where Peff = max(`period`,1). The >= compare makes a shrinking `period` take effect immediately.
  - On a tick: counter clears to 0, the word is loaded, `wr_en` is set, and the FSM goes to HOLD.
- **HOLD:** `wr_en`=1 and the counter keeps running.
  - `f_FIFO_writing_done` clears `wr_en`; the FSM goes to COUNT (or to IDLE if `enable`=0).
  - A tick without `done`: the event is dropped. `overrun` is set, `drop_cnt` increments, the counter clears, and the pending word is unchanged.
  - A tick and `done` in the same cycle: `done` acknowledges the old word and the new word is loaded. `wr_en` stays 1; no overrun.

Word load:
- `data` = {ptr, seq}; `channel` = ptr.
- Afterwards ptr <= (ptr == `CHANNELS`-1) ? 0 : ptr+1, and seq <= seq+1, wrapping modulo 2^(`DATA_WIDTH`-`CH_W`).
- Dropped events do not advance ptr or seq.

Other rules:
- `enable` deasserted: counter clears and no new ticks occur. A pending word remains and completes on `done`.
- `done` while `wr_en`=0 is ignored.
- `rst` mid-operation returns everything to reset values on the next edge. A pending word is discarded.

## Timing
- Outputs are registered; there is no combinational path from input to output.
- First word: with `enable` first sampled high at edge 1, `wr_en` is 1 after edge Peff.
- Steady state with `done` returned within Peff-1 cycles: one word every Peff cycles exactly.
- `done` sampled at edge n: `wr_en` is 0 after edge n, unless a same-cycle tick reloads it.
- Period=1: a tick every cycle. `done` held high continuously yields a new word every cycle with no overrun.

## Configuration
- `FAKE_TDC_JITTER_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; reset to seed) advances once per tick.
  - The tick threshold becomes Peff-1 + lfsr[3:0], giving 0..15 extra cycles per event.
- `FAKE_TDC_JITTER_EN` undefined: no LFSR logic; the period is exact.

## Test plan
- `rst`, then `enable`=1, `period`=10, `done` pulsed 2 cycles after each `wr_en` rise -> `wr_en` rises every 10 cycles. `data` = 0x000000, 0x400001, 0x800002, 0xC00003, 0x000004 (CHANNELS=4, DATA_WIDTH=24).
- `period`=5, `done` never asserted -> `wr_en` stuck at 1 with `data`=0x000000. `overrun`=1 after the second tick; `drop_cnt`=3 after 20 cycles.
- `period`=4, `done` asserted exactly on the tick cycle -> `wr_en` stays 1 continuously, a new word every 4 cycles, `overrun`=0.
- `period`=0 with `done` tied high -> a new word every cycle, seq incrementing by 1, no overrun.
- `rst` asserted while `wr_en`=1 and `drop_cnt`=2 -> all outputs 0 on the next edge. The next word after re-enable is `data`=0x000000.
- With `FAKE_TDC_JITTER_EN`, `period`=100, prompt `done` -> every inter-word gap is in 100..115 and the sequence matches the LFSR golden model.
